// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for a JK flip-flop: buffers {code,len} commands, replays each on jk_in
// for len+1 cycles and predicts the flip-flop's q. Define JKSEQ_ABORT_EN to add an abort input.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef JKSEQ_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_code,
  input  logic [LEN_W-1:0]       cmd_len,
  output logic [1:0]             jk_in,
  output logic                   busy,
  output logic                   done,
  output logic                   q_model,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [1:0] JK_HOLD = 2'b00;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_d;
  logic [LEN_W-1:0] remaining, remaining_d;
  logic [1:0]       jk_d;
  logic [1:0]       mem_code [DEPTH];
  logic [LEN_W-1:0] mem_len  [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             empty, full, push, pop, last;

  function automatic logic jk_next(input logic q, input logic [1:0] jk);
    case (jk)
      2'b01:   jk_next = 1'b0;
      2'b10:   jk_next = 1'b1;
      2'b11:   jk_next = ~q;
      default: jk_next = q;
    endcase
  endfunction

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign cmd_ready  = ~full;
  assign fifo_count = count;
  assign busy       = (state == RUN);
  assign last       = (state == RUN) && (remaining == '0);

`ifdef JKSEQ_ABORT_EN
  assign push = cmd_valid && !full && !abort;
  assign done = last && !abort;
`else
  assign push = cmd_valid && !full;
  assign done = last;
`endif

  // Command storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem_code[wr_ptr] <= cmd_code;
      mem_len[wr_ptr]  <= cmd_len;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end
`ifdef JKSEQ_ABORT_EN
    else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end
`endif
    else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // Next-state: the head is loaded from IDLE or on the final drive cycle, so back-to-back
  // commands leave no HOLD bubble.
  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    jk_d        = jk_in;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        jk_d = JK_HOLD;
        if (!empty) begin
          pop         = 1'b1;
          state_d     = RUN;
          remaining_d = mem_len[rd_ptr];
          jk_d        = mem_code[rd_ptr];
        end
      end
      RUN: begin
        if (remaining != '0) begin
          remaining_d = remaining - LEN_W'(1);
        end else if (!empty) begin
          pop         = 1'b1;
          remaining_d = mem_len[rd_ptr];
          jk_d        = mem_code[rd_ptr];
        end else begin
          state_d = IDLE;
          jk_d    = JK_HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        jk_d    = JK_HOLD;
      end
    endcase
`ifdef JKSEQ_ABORT_EN
    if (abort) begin
      state_d     = IDLE;
      remaining_d = '0;
      jk_d        = JK_HOLD;
      pop         = 1'b0;
    end
`endif
  end

  // State, drive register and q prediction (q follows the code on jk_in before this edge)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      jk_in     <= JK_HOLD;
      q_model   <= 1'b0;
    end else begin
      state     <= state_d;
      remaining <= remaining_d;
      jk_in     <= jk_d;
`ifdef JKSEQ_ABORT_EN
      if (!abort) q_model <= jk_next(q_model, jk_in);
`else
      q_model <= jk_next(q_model, jk_in);
`endif
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: directed vector table, multi-cycle corner sequences and
// random traffic checked against a queue-based reference model.
module tb_jk_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int LEN_W = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, cmd_valid, cmd_ready, busy, done, q_model, abort;
  logic [1:0]    cmd_code, jk_in;
  logic [LEN_W-1:0] cmd_len;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .rst(rst),
`ifdef JKSEQ_ABORT_EN
    .abort(abort),
`endif
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_code(cmd_code),
    .cmd_len(cmd_len),
    .jk_in(jk_in),
    .busy(busy),
    .done(done),
    .q_model(q_model),
    .fifo_count(fifo_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending commands in queues, current command as cycles-left-to-drive.
  int mq_code[$];
  int mq_len[$];
  bit m_act;
  int m_code, m_left, m_q;

  function automatic int jk_apply(input int q, input int c);
    case (c)
      1: return 0;
      2: return 1;
      3: return 1 - q;
      default: return q;
    endcase
  endfunction

  task automatic model_edge(input int r, input int v, input int c, input int l, input int a);
    bit can_push;
    if (r != 0) begin
      mq_code.delete(); mq_len.delete();
      m_act = 0; m_left = 0; m_q = 0;
      return;
    end
    if (a != 0) begin
      mq_code.delete(); mq_len.delete();
      m_act = 0; m_left = 0;
      return;
    end
    can_push = (v != 0) && (mq_len.size() < DEPTH);
    m_q = jk_apply(m_q, m_act ? m_code : 0);
    if (m_act && m_left > 1) begin
      m_left--;
    end else if (mq_len.size() > 0) begin
      m_code = mq_code.pop_front();
      m_left = mq_len.pop_front() + 1;
      m_act  = 1;
    end else begin
      m_act = 0;
    end
    if (can_push) begin
      mq_code.push_back(c);
      mq_len.push_back(l);
    end
  endtask

  task automatic drive_edge(input int r, input int v, input int c, input int l, input int a);
    rst = r[0]; cmd_valid = v[0]; cmd_code = c[1:0]; cmd_len = LEN_W'(l); abort = a[0];
    @(posedge clk);
    model_edge(r, v, c, l, a);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_jk"},    32'(jk_in),      32'(m_act ? m_code : 0));
    chk({tag, "_busy"},  32'(busy),       32'(m_act));
    chk({tag, "_done"},  32'(done),       32'(m_act && m_left == 1));
    chk({tag, "_q"},     32'(q_model),    32'(m_q));
    chk({tag, "_count"}, 32'(fifo_count), 32'(mq_len.size()));
    chk({tag, "_ready"}, 32'(cmd_ready),  32'(mq_len.size() < DEPTH));
  endtask

  task automatic step(input string tag, input int r, input int v, input int c, input int l,
                      input int a);
    drive_edge(r, v, c, l, a);
    check_model(tag);
  endtask

  typedef struct {
    int r, v, c, l;
    int jk, dn, q, cnt, bsy, rdy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int idx, n_busy, n_done;
    bit saw_bp;
    int bp_code[6];
    int qsave;

    rst = 1'b1; cmd_valid = 1'b0; cmd_code = 2'b00; cmd_len = '0; abort = 1'b0;
    m_act = 0; m_code = 0; m_left = 0; m_q = 0;

    // r v c l | jk done q count busy ready (values seen after the edge)
    tbl[0]  = '{1, 1, 2, 0,  0, 0, 0, 0, 0, 1};
    tbl[1]  = '{1, 1, 2, 0,  0, 0, 0, 0, 0, 1};
    tbl[2]  = '{0, 1, 2, 2,  0, 0, 0, 1, 0, 1};
    tbl[3]  = '{0, 0, 0, 0,  2, 0, 0, 0, 1, 1};
    tbl[4]  = '{0, 0, 0, 0,  2, 0, 1, 0, 1, 1};
    tbl[5]  = '{0, 0, 0, 0,  2, 1, 1, 0, 1, 1};
    tbl[6]  = '{0, 0, 0, 0,  0, 0, 1, 0, 0, 1};
    tbl[7]  = '{1, 0, 0, 0,  0, 0, 0, 0, 0, 1};
    tbl[8]  = '{0, 1, 3, 0,  0, 0, 0, 1, 0, 1};
    tbl[9]  = '{0, 1, 3, 0,  3, 1, 0, 1, 1, 1};
    tbl[10] = '{0, 1, 1, 1,  3, 1, 1, 1, 1, 1};
    tbl[11] = '{0, 0, 0, 0,  1, 0, 0, 0, 1, 1};
    tbl[12] = '{0, 0, 0, 0,  1, 1, 0, 0, 1, 1};
    tbl[13] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 1};

    for (int i = 0; i < 14; i++) begin
      drive_edge(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].l, 0);
      chk($sformatf("tbl%0d_jk", i),    32'(jk_in),      32'(tbl[i].jk));
      chk($sformatf("tbl%0d_done", i),  32'(done),       32'(tbl[i].dn));
      chk($sformatf("tbl%0d_q", i),     32'(q_model),    32'(tbl[i].q));
      chk($sformatf("tbl%0d_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),       32'(tbl[i].bsy));
      chk($sformatf("tbl%0d_ready", i), 32'(cmd_ready),  32'(tbl[i].rdy));
    end

    // Backpressure: six len=3 commands offered with valid held high
    bp_code = '{2, 3, 1, 3, 2, 1};
    step("bp_rst", 1, 0, 0, 0, 0);
    idx = 0; saw_bp = 0;
    for (int cyc = 0; cyc < 100 && idx < 6; cyc++) begin
      bit acc;
      acc = cmd_ready;
      if (!cmd_ready) begin
        saw_bp = 1;
        chk("bp_full_count", 32'(fifo_count), 32'(DEPTH));
      end
      step("bp", 0, 1, bp_code[idx], 3, 0);
      if (acc) idx++;
    end
    chk("bp_seen", 32'(saw_bp), 32'd1);
    chk("bp_all_pushed", 32'(idx), 32'd6);
    for (int cyc = 0; cyc < 100 && (m_act || mq_len.size() > 0); cyc++)
      step("bp_drain", 0, 0, 0, 0, 0);
    chk("bp_drained_busy", 32'(busy), 32'd0);

    // Maximum length: 2^LEN_W drive cycles, a single done
    step("max_rst", 1, 0, 0, 0, 0);
    step("max_push", 0, 1, 1, 15, 0);
    n_busy = 0; n_done = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step("max", 0, 0, 0, 0, 0);
      if (busy) n_busy++;
      if (done) n_done++;
    end
    chk("max_cycles", 32'(n_busy), 32'd16);
    chk("max_done_pulses", 32'(n_done), 32'd1);

    // Reset on the third drive cycle of a long SET with another command queued
    step("mid_rst0", 1, 0, 0, 0, 0);
    step("mid_push", 0, 1, 2, 7, 0);
    step("mid_d1", 0, 1, 3, 1, 0);
    step("mid_d2", 0, 0, 0, 0, 0);
    chk("mid_q_before", 32'(q_model), 32'd1);
    chk("mid_count_before", 32'(fifo_count), 32'd1);
    step("mid_d3", 0, 0, 0, 0, 0);
    step("mid_rst", 1, 0, 0, 0, 0);
    chk("mid_jk", 32'(jk_in), 32'd0);
    chk("mid_q", 32'(q_model), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_count", 32'(fifo_count), 32'd0);
    step("mid_after", 0, 0, 0, 0, 0);

`ifdef JKSEQ_ABORT_EN
    // Abort while the first of three queued commands is driving
    step("ab_rst", 1, 0, 0, 0, 0);
    step("ab_p1", 0, 1, 2, 5, 0);
    step("ab_p2", 0, 1, 3, 1, 0);
    step("ab_p3", 0, 1, 1, 1, 0);
    step("ab_run", 0, 0, 0, 0, 0);
    qsave = q_model;
    step("ab_hit", 0, 1, 3, 0, 1);
    chk("ab_jk", 32'(jk_in), 32'd0);
    chk("ab_count", 32'(fifo_count), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_q_kept", 32'(q_model), 32'(qsave));
    step("ab_after", 0, 0, 0, 0, 0);
`else
    qsave = 0;
`endif

    // Random traffic against the model
    step("rnd_rst", 1, 0, 0, 0, 0);
    for (int cyc = 0; cyc < 800; cyc++) begin
      int r, v, c, l, a;
      r = ($urandom_range(0, 79) == 0) ? 1 : 0;
      v = ($urandom_range(0, 9) < 6) ? 1 : 0;
      c = $urandom_range(0, 3);
      l = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
`ifdef JKSEQ_ABORT_EN
      a = ($urandom_range(0, 59) == 0) ? 1 : 0;
`else
      a = 0;
`endif
      step("rnd", r, v, c, l, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
